// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- byte FIFO feeding an 8N1 UART transmitter.
//
// Each 0->1 transition of i_Start enqueues i_Data. The transmitter drains the
// FIFO and sends frames back-to-back while data remains.
//
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
// between the data bits and the stop bit (11-bit frame). Without it the frame
// is start + 8 data + stop (10 bits).
//
// Ports:
//   i_Clock     system clock, rising edge
//   i_Reset_n   asynchronous active-low reset
//   i_Start     enqueue request (level; one byte per rising edge)
//   i_Data      byte captured on the detection cycle
//   o_UART      serial line, idle high, registered
//   o_Busy      FIFO non-empty or frame in progress
//   o_Full      FIFO holds 2**FIFO_AW entries
//   o_Overflow  sticky: a byte was dropped because the FIFO was full
//   o_Count     current FIFO occupancy
//
// FSM states:
//   state  | meaning
//   IDLE   | line high, waiting for FIFO data
//   START  | start bit (low)
//   DATA   | 8 data bits, LSB first
//   PARITY | even parity bit (only with UART_TX_PARITY_EN)
//   STOP   | stop bit (high); pops next byte at its end if available

module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 1042,
    parameter int FIFO_AW      = 3
) (
    input  logic               i_Clock,
    input  logic               i_Reset_n,
    input  logic               i_Start,
    input  logic [7:0]         i_Data,
    output logic               o_UART,
    output logic               o_Busy,
    output logic               o_Full,
    output logic               o_Overflow,
    output logic [FIFO_AW:0]   o_Count
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam int               DEPTH     = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] PTR_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [15:0]      BIT_LOAD  = 16'(CLKS_PER_BIT - 1);

    logic [7:0]       mem [DEPTH];
    logic [FIFO_AW:0] wr_ptr;
    logic [FIFO_AW:0] rd_ptr;
    logic [7:0]       head;

    logic             start_q;
    logic             armed;
    logic             start_rise;
    logic             push;
    logic             pop;

    state_t           state;
    logic [15:0]      bit_timer;
    logic             bit_done;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign o_Count  = wr_ptr - rd_ptr;
    assign o_Full   = (o_Count == DEPTH_CNT);
    assign o_Busy   = (state != IDLE) || (o_Count != '0);
    assign head     = mem[rd_ptr[FIFO_AW-1:0]];
    assign bit_done = (bit_timer == '0);

    // armed stays low for the first cycle after reset so that an i_Start
    // already high at release is taken as the old level, not a new edge.
    assign start_rise = i_Start && !start_q && armed;

    assign pop  = (o_Count != '0) && ((state == IDLE) || ((state == STOP) && bit_done));
    assign push = start_rise && (!o_Full || pop);

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            start_q    <= 1'b0;
            armed      <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_Overflow <= 1'b0;
        end else begin
            start_q <= i_Start;
            armed   <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (start_rise && o_Full && !pop) begin
                o_Overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge i_Clock) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= i_Data;
        end
    end

`ifdef UART_TX_PARITY_EN
    logic parity;

    // Parity is taken from the byte as it leaves the FIFO, before shifting.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            parity <= 1'b0;
        end else if (pop) begin
            parity <= ^head;
        end
    end
`endif

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state     <= IDLE;
            bit_timer <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            o_UART    <= 1'b1;
        end else begin
            // Line level follows the state one cycle later, so every bit on
            // the wire still lasts exactly CLKS_PER_BIT cycles.
            case (state)
                START:   o_UART <= 1'b0;
                DATA:    o_UART <= shift[0];
`ifdef UART_TX_PARITY_EN
                PARITY:  o_UART <= parity;
`endif
                default: o_UART <= 1'b1;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        shift     <= head;
                        bit_timer <= BIT_LOAD;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        bit_timer <= BIT_LOAD;
                        bit_idx   <= '0;
                        state     <= DATA;
                    end else begin
                        bit_timer <= bit_timer - 16'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        bit_timer <= BIT_LOAD;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= shift >> 1;
                        end
                    end else begin
                        bit_timer <= bit_timer - 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        bit_timer <= BIT_LOAD;
                        state     <= STOP;
                    end else begin
                        bit_timer <= bit_timer - 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        if (pop) begin
                            shift     <= head;
                            bit_timer <= BIT_LOAD;
                            state     <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_timer <= bit_timer - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
